ap_host_sequencer: RTL and testbench

AP_HOST_SEQUENCER -- requirements
Module: ap_host_sequencer

---
 rtl/ap_host_sequencer_if.sv | 43 ++++
 rtl/ap_host_sequencer.sv | 173 +++++++++++++++++
 tb/tb_ap_host_sequencer.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ap_host_sequencer_if.sv
// Bundles the host control/load/readback handshakes and the AP-side bus of ap_host_sequencer.
// The sequencer uses the slave modport; the host and AP environment use the master modport.
interface ap_host_sequencer_if #(
   parameter int WORD_SIZE = 8,
   parameter int ADDR_W    = 10
);
   logic                 start;
   logic [2:0]           cmd_in;
   logic                 busy;
   logic                 done;
   logic                 error;
   logic                 ld_valid;
   logic                 ld_ready;
   logic [WORD_SIZE-1:0] ld_data;
   logic                 rd_valid;
   logic                 rd_ready;
   logic [WORD_SIZE-1:0] rd_data;
   logic [ADDR_W-1:0]    ap_addr;
   logic [WORD_SIZE-1:0] ap_data;
   logic                 ap_rst;
   logic                 ap_mode;
   logic [2:0]           ap_cmd;
   logic [1:0]           ap_sel_col;
   logic                 ap_sel_internal_col;
   logic                 ap_write_en;
   logic                 ap_read_en;
   logic [WORD_SIZE-1:0] ap_data_out;
   logic                 ap_state_irq;

   modport slave (
      input  start, cmd_in, ld_valid, ld_data, rd_ready, ap_data_out, ap_state_irq,
      output busy, done, error, ld_ready, rd_valid, rd_data,
             ap_addr, ap_data, ap_rst, ap_mode, ap_cmd, ap_sel_col,
             ap_sel_internal_col, ap_write_en, ap_read_en
   );

   modport master (
      output start, cmd_in, ld_valid, ld_data, rd_ready, ap_data_out, ap_state_irq,
      input  busy, done, error, ld_ready, rd_valid, rd_data,
             ap_addr, ap_data, ap_rst, ap_mode, ap_cmd, ap_sel_col,
             ap_sel_internal_col, ap_write_en, ap_read_en
   );
endinterface

// File: rtl/ap_host_sequencer.sv
// Host-side job sequencer for an associative processor: clears the array, streams B then A
// operands in, runs the compute phase with a timeout, then reads every result cell back.
module ap_host_sequencer #(
   parameter int WORD_SIZE  = 8,
   parameter int CELL_QUANT = 512,
   parameter int ADDR_W     = 10,
   parameter int RD_LAT     = 1,
   parameter int TIMEOUT    = 4096
) (
   input logic                CLK100MHZ,
   input logic                rst_n,
   ap_host_sequencer_if.slave bus
);
   localparam int CYC_W = $clog2(TIMEOUT) + 1;
   localparam int LAT_W = $clog2(RD_LAT) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELL_QUANT - 1);
   localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(TIMEOUT - 1);
   localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(RD_LAT - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_CLR0, S_CLR1, S_LOAD_B, S_LOAD_A,
      S_COMPUTE, S_RD_ISSUE, S_RD_WAIT, S_RD_HOLD, S_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    cnt_q, cnt_d;
   logic [CYC_W-1:0]     cyc_q, cyc_d;
   logic [LAT_W-1:0]     lat_q, lat_d;
   logic [2:0]           cmd_q, cmd_d;
   logic [WORD_SIZE-1:0] rd_data_q, rd_data_d;
   logic                 wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
   logic [WORD_SIZE-1:0] wr_data_q, wr_data_d;
   logic                 wr_sel_b_q, wr_sel_b_d;
   logic                 error_q, error_d;

   // State and datapath registers
   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         cyc_q      <= '0;
         lat_q      <= '0;
         cmd_q      <= 3'd0;
         rd_data_q  <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_sel_b_q <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cyc_q      <= cyc_d;
         lat_q      <= lat_d;
         cmd_q      <= cmd_d;
         rd_data_q  <= rd_data_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_sel_b_q <= wr_sel_b_d;
         error_q    <= error_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cyc_d      = cyc_q;
      lat_d      = lat_q;
      cmd_d      = cmd_q;
      rd_data_d  = rd_data_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_sel_b_d = wr_sel_b_q;
      error_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start && (bus.cmd_in == 3'd7)) begin
               error_d = 1'b1;
            end else if (bus.start) begin
               cmd_d   = bus.cmd_in;
               state_d = S_CLR0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CLR0: state_d = S_CLR1;
         S_CLR1: begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
         end
         S_LOAD_B, S_LOAD_A: begin
            if (bus.ld_valid) begin
               wr_en_d    = 1'b1;
               wr_addr_d  = cnt_q;
               wr_data_d  = bus.ld_data;
               wr_sel_b_d = (state_q == S_LOAD_B);
               if (cnt_q == LAST_ADDR) begin
                  cnt_d   = '0;
                  cyc_d   = '0;
                  state_d = (state_q == S_LOAD_B) ? S_LOAD_A : S_COMPUTE;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end else begin
               wr_en_d = 1'b0;
            end
         end
         S_COMPUTE: begin
            // Compute starts only once the final A word has landed in the array
            if (wr_en_q) begin
               cyc_d = '0;
            end else if (bus.ap_state_irq) begin
               cnt_d   = '0;
               state_d = S_RD_ISSUE;
            end else if (cyc_q == LAST_CYC) begin
               error_d = 1'b1;
               state_d = S_IDLE;
            end else begin
               cyc_d = cyc_q + CYC_W'(1);
            end
         end
         S_RD_ISSUE: begin
            lat_d   = '0;
            state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (lat_q == LAST_LAT) begin
               rd_data_d = bus.ap_data_out;
               state_d   = S_RD_HOLD;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         S_RD_HOLD: begin
            if (bus.rd_ready && (cnt_q == LAST_ADDR)) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else if (bus.rd_ready) begin
               cnt_d   = cnt_q + ADDR_W'(1);
               state_d = S_RD_ISSUE;
            end else begin
               state_d = S_RD_HOLD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode only registered state, so all of them sit at 0 while rst_n is low
   assign bus.busy                = (state_q != S_IDLE);
   assign bus.done                = (state_q == S_DONE);
   assign bus.error               = error_q;
   assign bus.ld_ready            = (state_q == S_LOAD_B) || (state_q == S_LOAD_A);
   assign bus.rd_valid            = (state_q == S_RD_HOLD);
   assign bus.rd_data             = rd_data_q;
   assign bus.ap_rst              = (state_q == S_CLR0) || (state_q == S_CLR1);
   assign bus.ap_sel_internal_col = (state_q == S_CLR1);
   assign bus.ap_mode             = (state_q == S_COMPUTE) && !wr_en_q;
   assign bus.ap_cmd              = (state_q == S_COMPUTE) ? cmd_q : 3'd0;
   assign bus.ap_write_en         = wr_en_q;
   assign bus.ap_read_en          = (state_q == S_RD_ISSUE);
   assign bus.ap_addr             = (state_q == S_RD_ISSUE) ? cnt_q : wr_addr_q;
   assign bus.ap_data             = wr_data_q;
   // A write still in flight keeps the column it was accepted under
   assign bus.ap_sel_col          = (state_q == S_RD_ISSUE) ? 2'd2 :
                                    wr_en_q                 ? {1'b0, wr_sel_b_q} :
                                    (state_q == S_LOAD_B)   ? 2'd1 : 2'd0;
endmodule

// File: tb/tb_ap_host_sequencer.sv
// Directed bench for ap_host_sequencer: host driver, simple AP read model and bus monitor.
module tb_ap_host_sequencer;
   localparam int WS = 8;
   localparam int CQ = 512;
   localparam int AW = 10;
   localparam int RL = 1;
   localparam int TO = 64;

   logic CLK100MHZ = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK100MHZ = ~CLK100MHZ;

   ap_host_sequencer_if #(.WORD_SIZE(WS), .ADDR_W(AW)) bus ();

   ap_host_sequencer #(
      .WORD_SIZE(WS), .CELL_QUANT(CQ), .ADDR_W(AW), .RD_LAT(RL), .TIMEOUT(TO)
   ) dut (
      .CLK100MHZ(CLK100MHZ),
      .rst_n    (rst_n),
      .bus      (bus.slave)
   );

   logic [40:0] all_out;
   logic [27:0] ap_vec;
   assign ap_vec  = {bus.ap_addr, bus.ap_data, bus.ap_rst, bus.ap_mode, bus.ap_cmd,
                     bus.ap_sel_col, bus.ap_sel_internal_col, bus.ap_write_en, bus.ap_read_en};
   assign all_out = {bus.busy, bus.done, bus.error, bus.ld_ready, bus.rd_valid, bus.rd_data, ap_vec};

   function automatic logic [7:0] pat(input int i);
      int v;
      v = i * 7 + 3;
      return v[7:0];
   endfunction

   // AP read model: data appears one cycle after read_en, zero otherwise
   always @(posedge CLK100MHZ)
      bus.ap_data_out <= bus.ap_read_en ? (bus.ap_addr[7:0] ^ 8'hA5) : 8'h00;

   int job_wr = 0, job_rd = 0, wr_bad = 0, rd_bad = 0, excl_bad = 0, done_cnt = 0;
   int rd_hits [CQ];

   // Bus monitor, restarts its per-job indices on every array clear
   always @(negedge CLK100MHZ) begin
      if (bus.ap_rst) begin
         job_wr <= 0;
         job_rd <= 0;
         for (int i = 0; i < CQ; i++) rd_hits[i] <= 0;
      end else begin
         if (bus.ap_write_en) begin
            if (bus.ap_addr !== AW'(job_wr % CQ) || bus.ap_data !== pat(job_wr) ||
                bus.ap_sel_col !== ((job_wr < CQ) ? 2'd1 : 2'd0))
               wr_bad <= wr_bad + 1;
            job_wr <= job_wr + 1;
         end
         if (bus.ap_read_en) begin
            if (bus.ap_addr !== AW'(job_rd) || bus.ap_sel_col !== 2'd2) rd_bad <= rd_bad + 1;
            if (int'(bus.ap_addr) < CQ) rd_hits[bus.ap_addr] <= rd_hits[bus.ap_addr] + 1;
            job_rd <= job_rd + 1;
         end
      end
      if (int'(bus.ap_write_en) + int'(bus.ap_read_en) + int'(bus.ap_rst) > 1) excl_bad <= excl_bad + 1;
      if (bus.done) done_cnt <= done_cnt + 1;
   end

   task automatic load_words(input bit toggle, input int stop_at, output int acc);
      int n;
      bit tog;
      acc = 0;
      n   = 0;
      tog = 1'b1;
      while (acc < stop_at && n < 8000) begin
         if (bus.ld_ready && tog) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = pat(acc);
            acc++;
         end else begin
            bus.ld_valid = 1'b0;
         end
         if (toggle) tog = !tog;
         n++;
         @(negedge CLK100MHZ);
      end
      bus.ld_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge CLK100MHZ);
      checks++;
      if (all_out !== 41'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", all_out); end
      rst_n = 1'b1;
      repeat (2) @(negedge CLK100MHZ);
      checks++;
      if (all_out !== 41'd0) begin errors++; $display("FAIL idle_outputs got %h want 0", all_out); end
   endtask

   task automatic test_invalid_cmd();
      bus.start = 1'b1;
      bus.cmd_in = 3'd7;
      bus.ap_state_irq = 1'b1;
      @(negedge CLK100MHZ);
      bus.start = 1'b0;
      bus.cmd_in = 3'd0;
      bus.ap_state_irq = 1'b0;
      checks++;
      if ({bus.error, bus.busy} !== 2'b10 || ap_vec !== 28'd0) begin
         errors++; $display("FAIL invalid_err_pulse got err=%b busy=%b ap=%h want err=1 busy=0 ap=0", bus.error, bus.busy, ap_vec);
      end
      @(negedge CLK100MHZ);
      checks++;
      if ({bus.error, bus.busy} !== 2'b00 || ap_vec !== 28'd0) begin
         errors++; $display("FAIL invalid_after got err=%b busy=%b ap=%h want all 0", bus.error, bus.busy, ap_vec);
      end
   endtask

   task automatic test_happy_path();
      int acc, n, wr0, rd0, dn0, badhits;
      bit tmo, stable;
      logic [9:0] wa;
      logic [7:0] e;
      wr0 = wr_bad; rd0 = rd_bad; dn0 = done_cnt;
      bus.start = 1'b1;
      bus.cmd_in = 3'd4;
      @(negedge CLK100MHZ);
      bus.cmd_in = 3'd7;
      checks++;
      if ({bus.ap_rst, bus.ap_sel_internal_col, bus.busy, bus.ld_ready, bus.error} !== 5'b10100) begin
         errors++; $display("FAIL clr0 got rst=%b int=%b busy=%b", bus.ap_rst, bus.ap_sel_internal_col, bus.busy);
      end
      @(negedge CLK100MHZ);
      bus.start = 1'b0;
      bus.cmd_in = 3'd0;
      checks++;
      if ({bus.ap_rst, bus.ap_sel_internal_col, bus.busy, bus.ld_ready, bus.error} !== 5'b11100) begin
         errors++; $display("FAIL clr1 got rst=%b int=%b busy=%b err=%b", bus.ap_rst, bus.ap_sel_internal_col, bus.busy, bus.error);
      end
      @(negedge CLK100MHZ);
      checks++;
      if ({bus.ap_rst, bus.ld_ready, bus.ap_sel_col, bus.error} !== 5'b01010) begin
         errors++; $display("FAIL load_b_entry got rst=%b rdy=%b sel=%0d", bus.ap_rst, bus.ld_ready, bus.ap_sel_col);
      end
      load_words(1'b1, 2 * CQ, acc);
      checks++;
      if (acc != 2 * CQ || bus.ld_ready !== 1'b0) begin
         errors++; $display("FAIL load_count got %0d rdy=%b want %0d rdy=0", acc, bus.ld_ready, 2 * CQ);
      end
      n = 0;
      while (bus.ap_mode !== 1'b1 && n < 10) begin @(negedge CLK100MHZ); n++; end
      checks++;
      if (bus.ap_mode !== 1'b1 || bus.ap_cmd !== 3'd4) begin
         errors++; $display("FAIL compute_entry got mode=%b cmd=%0d want 1 4", bus.ap_mode, bus.ap_cmd);
      end
      repeat (49) @(negedge CLK100MHZ);
      bus.ap_state_irq = 1'b1;
      @(negedge CLK100MHZ);
      bus.ap_state_irq = 1'b0;
      checks++;
      if ({bus.ap_mode, bus.ap_read_en} !== 2'b01 || bus.ap_addr !== 10'd0) begin
         errors++; $display("FAIL irq_exit got mode=%b rd_en=%b addr=%0d want 0 1 0", bus.ap_mode, bus.ap_read_en, bus.ap_addr);
      end
      tmo = 1'b0;
      for (int w = 0; w < CQ && !tmo; w++) begin
         wa = w[9:0];
         e  = wa[7:0] ^ 8'hA5;
         n  = 0;
         while (bus.rd_valid !== 1'b1 && n < 50) begin @(negedge CLK100MHZ); n++; end
         checks++;
         if (bus.rd_valid !== 1'b1) begin
            errors++; tmo = 1'b1; $display("FAIL rd_valid_timeout word %0d got 0 want 1", w);
         end else if (bus.rd_data !== e) begin
            errors++; $display("FAIL rd_data word %0d got %h want %h", w, bus.rd_data, e);
         end
         if (w == 3 && !tmo) begin
            stable = 1'b1;
            repeat (20) begin
               @(negedge CLK100MHZ);
               if (bus.rd_data !== e || bus.rd_valid !== 1'b1) stable = 1'b0;
            end
            checks++;
            if (!stable) begin errors++; $display("FAIL rd_hold_stable got changed want %h held", e); end
         end
         bus.rd_ready = 1'b1;
         @(negedge CLK100MHZ);
         bus.rd_ready = 1'b0;
      end
      checks++;
      if (bus.done !== 1'b1 || bus.rd_valid !== 1'b0) begin
         errors++; $display("FAIL done_pulse got done=%b rdv=%b want 1 0", bus.done, bus.rd_valid);
      end
      @(negedge CLK100MHZ);
      checks++;
      if ({bus.done, bus.busy} !== 2'b00) begin
         errors++; $display("FAIL done_after got done=%b busy=%b want 0 0", bus.done, bus.busy);
      end
      badhits = 0;
      for (int i = 0; i < CQ; i++) if (rd_hits[i] != 1) badhits++;
      checks++;
      if (job_wr != 2 * CQ || wr_bad != wr0) begin
         errors++; $display("FAIL write_stream got %0d writes %0d bad want %0d 0", job_wr, wr_bad - wr0, 2 * CQ);
      end
      checks++;
      if (job_rd != CQ || rd_bad != rd0 || badhits != 0 || done_cnt != dn0 + 1) begin
         errors++; $display("FAIL read_stream got rd=%0d bad=%0d hits=%0d done=%0d want %0d 0 0 1", job_rd, rd_bad - rd0, badhits, done_cnt - dn0, CQ);
      end
   endtask

   task automatic test_timeout();
      int acc, n, k, wr0;
      bit mode_ok;
      wr0 = wr_bad;
      bus.start = 1'b1;
      bus.cmd_in = 3'd0;
      @(negedge CLK100MHZ);
      bus.start = 1'b0;
      load_words(1'b0, 2 * CQ, acc);
      n = 0;
      while (bus.ap_mode !== 1'b1 && n < 10) begin @(negedge CLK100MHZ); n++; end
      k = 0;
      mode_ok = 1'b1;
      while (bus.error !== 1'b1 && k < 200) begin
         @(negedge CLK100MHZ);
         k++;
         if (bus.error !== 1'b1 && bus.ap_mode !== 1'b1) mode_ok = 1'b0;
      end
      checks++;
      if (k != TO || !mode_ok) begin
         errors++; $display("FAIL timeout_delay got %0d mode_ok=%b want %0d 1", k, mode_ok, TO);
      end
      checks++;
      if ({bus.ap_mode, bus.busy, bus.rd_valid, bus.ap_read_en} !== 4'b0000) begin
         errors++; $display("FAIL timeout_state got mode=%b busy=%b want 0 0", bus.ap_mode, bus.busy);
      end
      @(negedge CLK100MHZ);
      checks++;
      if (bus.error !== 1'b0 || job_rd != 0 || job_wr != 2 * CQ || wr_bad != wr0) begin
         errors++; $display("FAIL timeout_after got err=%b rd=%0d wr=%0d want 0 0 %0d", bus.error, job_rd, job_wr, 2 * CQ);
      end
   endtask

   task automatic test_reset_midop();
      int acc, dn0;
      dn0 = done_cnt;
      bus.start = 1'b1;
      bus.cmd_in = 3'd1;
      @(negedge CLK100MHZ);
      bus.start = 1'b0;
      load_words(1'b0, CQ + 101, acc);
      checks++;
      if ({bus.ap_write_en, bus.ld_ready} !== 2'b11 || bus.ap_addr !== 10'd100 || bus.ap_sel_col !== 2'd0) begin
         errors++; $display("FAIL load_a_100 got we=%b addr=%0d sel=%0d want 1 100 0", bus.ap_write_en, bus.ap_addr, bus.ap_sel_col);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (all_out !== 41'd0) begin errors++; $display("FAIL midop_reset got %h want 0", all_out); end
      @(negedge CLK100MHZ);
      rst_n = 1'b1;
      @(negedge CLK100MHZ);
      bus.start = 1'b1;
      bus.cmd_in = 3'd6;
      @(negedge CLK100MHZ);
      bus.start = 1'b0;
      checks++;
      if ({bus.ap_rst, bus.ap_sel_internal_col, bus.busy} !== 3'b101) begin
         errors++; $display("FAIL restart_clr0 got rst=%b int=%b busy=%b want 1 0 1", bus.ap_rst, bus.ap_sel_internal_col, bus.busy);
      end
      @(negedge CLK100MHZ);
      checks++;
      if (done_cnt != dn0) begin errors++; $display("FAIL abort_no_done got %0d want 0", done_cnt - dn0); end
      rst_n = 1'b0;
      @(negedge CLK100MHZ);
      checks++;
      if (excl_bad != 0) begin errors++; $display("FAIL one_hot_strobes got %0d want 0", excl_bad); end
   endtask

   initial begin
      rst_n = 1'b1;
      bus.start = 1'b0;
      bus.cmd_in = 3'd0;
      bus.ld_valid = 1'b0;
      bus.ld_data = 8'd0;
      bus.rd_ready = 1'b0;
      bus.ap_state_irq = 1'b0;
      #2;
      test_reset();
      test_invalid_cmd();
      test_happy_path();
      test_timeout();
      test_reset_midop();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
